mmss_timer: RTL
===============

# mmss_timer

Synchronous MM:SS countdown timer core for the UP2 timer design. Takes single-cycle command pulses from the debounced/edge-detected button path, keeps minutes and seconds as four registered BCD digits, and counts down at 1 Hz derived internally from the main clock. The digits feed the four `bcd_to_7seg` decoders directly. It replaces the ripple-clocked counter chain and toggle flip-flop with a single-clock FSM.

## Interface
- `CLK_HZ`, default 25175000: main clock frequency; sets the 1 Hz prescaler terminal count (`CLK_HZ-1`).
- `MCLK`  in  1  main clock; all state updates on its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `START_STOP_P`  in  1  one-cycle pulse; toggles run/stop.
- `CLEAR_P`  in  1  one-cycle pulse; zeroes the time while stopped.
- `ADD_SEC_P`  in  1  one-cycle pulse; +1 second while stopped.
- `ADD_MIN_P`  in  1  one-cycle pulse; +1 minute while stopped.
- `MIN_1`  out  3  tens of minutes, BCD 0..5.
- `MIN_0`  out  4  units of minutes, BCD 0..9.
- `SEC_1`  out  3  tens of seconds, BCD 0..5.
- `SEC_0`  out  4  units of seconds, BCD 0..9.
- `RUNNING`  out  1  high in RUN.
- `ALARM`  out  1  high in EXPIRED.
- `BLANK`  out  1  display blank request; decoders drive all segments off when high.

## Operation
- States: STOP, RUN, EXPIRED. On reset: STOP, all digits 0, prescaler 0, all outputs 0.
- STOP:
  - `START_STOP_P` with time ≠ 00:00 → RUN and prescaler cleared to 0. With time = 00:00 the pulse is ignored.
  - `CLEAR_P` → all digits 0.
  - `ADD_SEC_P` → seconds field +1, wraps 59→00 with no carry into minutes.
  - `ADD_MIN_P` → minutes field +1, wraps 59→00.
- RUN:
  - The prescaler counts 0..`CLK_HZ-1`. At the terminal count it generates a tick and returns to 0.
  - On a tick, time decrements by one second: `SEC_0` borrows into `SEC_1` (0→9), `SEC_1` into `MIN_0` (0→5), `MIN_0` into `MIN_1` (0→9).
  - A tick that takes the time from 00:01 to 00:00 also moves the state to EXPIRED in the same cycle.
  - `START_STOP_P` → STOP. Time and prescaler are held; a later start clears the prescaler.
  - `CLEAR_P`, `ADD_SEC_P` and `ADD_MIN_P` are ignored.
- EXPIRED:
  - Time is held at 00:00.
  - Any of `START_STOP_P`, `CLEAR_P`, `ADD_SEC_P`, `ADD_MIN_P` → STOP. That pulse is consumed and has no other effect.
- Priority within one cycle: `RST` > `START_STOP_P` > `CLEAR_P` > `ADD_SEC_P`/`ADD_MIN_P`.
  - `ADD_SEC_P` and `ADD_MIN_P` together in STOP: both apply.
  - `CLEAR_P` with either ADD in STOP: clear wins, result 00:00.
- Digit values are never outside their BCD ranges.

## Timing
- All outputs are registered. A command pulse at edge N is visible on the outputs after edge N+1.
- The first decrement after a start occurs exactly `CLK_HZ` cycles after the start pulse; later decrements follow every `CLK_HZ` cycles.
- `RUNNING` and `ALARM` change on the same edge as the state register.
- `RST` asserted mid-run: the next edge forces STOP, 00:00, prescaler 0; this overrides any pulse in the same cycle.
- Inputs must be synchronous to `MCLK`. The block does no synchronization or debouncing.

## Configuration
- `MMSS_TIMER_BLINK_EN` defined:
  - In EXPIRED, `BLANK` toggles every `CLK_HZ/4` cycles (2 Hz blink), starting at 0 on entry.
  - `BLANK` is forced to 0 on leaving EXPIRED.
  - This uses a dedicated counter.
- Not defined: `BLANK` is tied to 0, and no blink counter is synthesized.

## Test plan
Bench parameter for all scenarios: `CLK_HZ=4`.
- Reset, then 3×`ADD_SEC_P` and 2×`ADD_MIN_P` → digits 0,2,0,3 (02:03), `RUNNING`=0.
- Set to 00:02, `START_STOP_P` at cycle 0 → 00:01 after cycle 4, 00:00 after cycle 8 with `ALARM`=1, `RUNNING`=0.
- Set 00:59 then `ADD_SEC_P` → 00:00. Set 59:00 then `ADD_MIN_P` → 00:00. Start at 10:00; after one tick → 09:59.
- In RUN, `ADD_SEC_P` and `CLEAR_P` → no change. `START_STOP_P` mid-second, then start again → the next decrement comes 4 cycles after the restart.
- `START_STOP_P` at 00:00 → stays STOP. In EXPIRED, `ADD_SEC_P` → STOP at 00:00, not 00:01. `CLEAR_P`+`ADD_MIN_P` in the same cycle in STOP → 00:00.
- With `MMSS_TIMER_BLINK_EN`: in EXPIRED, `BLANK` toggles every cycle (`CLK_HZ/4`=1) and is 0 after exit. Without the macro, `BLANK` stays 0. `RST` during RUN at 05:17 → 00:00, STOP on the next edge.

Source files
------------

// File: rtl/mmss_timer.sv
// mmss_timer: MM:SS countdown timer core with BCD digit outputs.
// Single-clock FSM (STOP / RUN / EXPIRED) with an internal 1 Hz prescaler.
// Optional feature: define MMSS_TIMER_BLINK_EN to blink BLANK at 2 Hz in EXPIRED.
module mmss_timer #(
    parameter int unsigned CLK_HZ = 25175000
) (
    input  logic       MCLK,
    input  logic       RST,
    input  logic       START_STOP_P,
    input  logic       CLEAR_P,
    input  logic       ADD_SEC_P,
    input  logic       ADD_MIN_P,
    output logic [2:0] MIN_1,
    output logic [3:0] MIN_0,
    output logic [2:0] SEC_1,
    output logic [3:0] SEC_0,
    output logic       RUNNING,
    output logic       ALARM,
    output logic       BLANK
);

    localparam int unsigned PrescW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        StStop    = 2'b00,
        StRun     = 2'b01,
        StExpired = 2'b10
    } state_e;

    state_e            r_state, w_state_next;
    logic [PrescW-1:0] r_presc, w_presc_next;
    logic [2:0]        r_min1, w_min1_next;
    logic [3:0]        r_min0, w_min0_next;
    logic [2:0]        r_sec1, w_sec1_next;
    logic [3:0]        r_sec0, w_sec0_next;

    logic w_tick;
    logic w_time_zero;
    logic w_time_one;
    logic w_any_pulse;

    assign w_tick      = (r_presc == PrescMax);
    assign w_time_zero = (r_min1 == 3'd0) && (r_min0 == 4'd0) &&
                         (r_sec1 == 3'd0) && (r_sec0 == 4'd0);
    assign w_time_one  = (r_min1 == 3'd0) && (r_min0 == 4'd0) &&
                         (r_sec1 == 3'd0) && (r_sec0 == 4'd1);
    assign w_any_pulse = START_STOP_P | CLEAR_P | ADD_SEC_P | ADD_MIN_P;

    // State register, prescaler and time digits
    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state <= StStop;
            r_presc <= '0;
            r_min1  <= 3'd0;
            r_min0  <= 4'd0;
            r_sec1  <= 3'd0;
            r_sec0  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_min1  <= w_min1_next;
            r_min0  <= w_min0_next;
            r_sec1  <= w_sec1_next;
            r_sec0  <= w_sec0_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StStop: begin
                if (START_STOP_P && !w_time_zero) w_state_next = StRun;
            end
            StRun: begin
                // A stop pulse on the terminal-count cycle wins over the tick
                if (START_STOP_P)            w_state_next = StStop;
                else if (w_tick && w_time_one) w_state_next = StExpired;
            end
            StExpired: begin
                if (w_any_pulse) w_state_next = StStop;
            end
            default: w_state_next = StStop;
        endcase
    end

    // Datapath next values: prescaler and BCD time digits
    always_comb begin
        w_presc_next = r_presc;
        w_min1_next  = r_min1;
        w_min0_next  = r_min0;
        w_sec1_next  = r_sec1;
        w_sec0_next  = r_sec0;
        unique case (r_state)
            StStop: begin
                if (START_STOP_P) begin
                    if (!w_time_zero) w_presc_next = '0;
                end else if (CLEAR_P) begin
                    w_min1_next = 3'd0;
                    w_min0_next = 4'd0;
                    w_sec1_next = 3'd0;
                    w_sec0_next = 4'd0;
                end else begin
                    if (ADD_SEC_P) begin
                        if (r_sec0 == 4'd9) begin
                            w_sec0_next = 4'd0;
                            w_sec1_next = (r_sec1 == 3'd5) ? 3'd0 : r_sec1 + 3'd1;
                        end else begin
                            w_sec0_next = r_sec0 + 4'd1;
                        end
                    end
                    if (ADD_MIN_P) begin
                        if (r_min0 == 4'd9) begin
                            w_min0_next = 4'd0;
                            w_min1_next = (r_min1 == 3'd5) ? 3'd0 : r_min1 + 3'd1;
                        end else begin
                            w_min0_next = r_min0 + 4'd1;
                        end
                    end
                end
            end
            StRun: begin
                if (!START_STOP_P) begin
                    if (w_tick) begin
                        w_presc_next = '0;
                        // Borrow chain; time is never 00:00 while running
                        if (r_sec0 != 4'd0) begin
                            w_sec0_next = r_sec0 - 4'd1;
                        end else begin
                            w_sec0_next = 4'd9;
                            if (r_sec1 != 3'd0) begin
                                w_sec1_next = r_sec1 - 3'd1;
                            end else begin
                                w_sec1_next = 3'd5;
                                if (r_min0 != 4'd0) begin
                                    w_min0_next = r_min0 - 4'd1;
                                end else begin
                                    w_min0_next = 4'd9;
                                    w_min1_next = r_min1 - 3'd1;
                                end
                            end
                        end
                    end else begin
                        w_presc_next = r_presc + PrescW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef MMSS_TIMER_BLINK_EN
    localparam int unsigned BlinkDiv = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int unsigned BlinkW   = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BlinkDiv - 1);

    logic [BlinkW-1:0] r_blink_cnt;
    logic              r_blank;

    // Blink counter: runs only while staying in EXPIRED, otherwise parked at 0
    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if ((r_state == StExpired) && (w_state_next == StExpired)) begin
            if (r_blink_cnt == BlinkMax) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + BlinkW'(1);
            end
        end else begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end
    end
`endif

    // Outputs come straight from registers
    always_comb begin
        MIN_1   = r_min1;
        MIN_0   = r_min0;
        SEC_1   = r_sec1;
        SEC_0   = r_sec0;
        RUNNING = (r_state == StRun);
        ALARM   = (r_state == StExpired);
`ifdef MMSS_TIMER_BLINK_EN
        BLANK   = r_blank;
`else
        BLANK   = 1'b0;
`endif
    end

endmodule
